// File: rtl/pwm_compare_if.sv
// Signal bundle between the upstream counter/duty source and the PWM comparator.
// Member names follow the block's external pin names.
interface pwm_compare_if #(
  parameter int unsigned WIDTH = 4
);
  logic             EN;
  logic [WIDTH-1:0] CNT;
  logic [WIDTH:0]   DUTY_IN;
  logic             LOAD;
  logic             PWM;
  logic             WRAP;
  logic             BUSY;

  modport master (
    output EN,
    output CNT,
    output DUTY_IN,
    output LOAD,
    input  PWM,
    input  WRAP,
    input  BUSY
  );

  modport slave (
    input  EN,
    input  CNT,
    input  DUTY_IN,
    input  LOAD,
    output PWM,
    output WRAP,
    output BUSY
  );
endinterface

// File: rtl/pwm_compare.sv
// Registered PWM comparator fed by a free-running counter, with a double-buffered duty
// register that only switches on a genuine MAX->0 counter wrap.
module pwm_compare #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  pwm_compare_if.slave     bus
);

  localparam logic [WIDTH-1:0] MaxC     = '1;
  localparam logic [WIDTH:0]   DutyFull = {1'b1, {WIDTH{1'b0}}};

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   duty_act_q, duty_act_d;
  logic [WIDTH:0]   duty_pend_q, duty_pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic             pwm_q, pwm_d;
  logic             wrap_q, wrap_d;

  logic             wrap;
  logic [WIDTH:0]   duty_clamped;
  logic [WIDTH:0]   duty_eff;

  // A counter reset that drops to zero from a non-terminal value is not a wrap.
  assign wrap         = bus.EN & (cnt_q == MaxC) & (bus.CNT == '0);
  assign duty_clamped = (bus.DUTY_IN > DutyFull) ? DutyFull : bus.DUTY_IN;
  assign duty_eff     = (wrap & pend_valid_q) ? duty_pend_q : duty_act_q;

  always_comb begin
    cnt_d        = bus.CNT;
    duty_act_d   = duty_act_q;
    duty_pend_d  = duty_pend_q;
    pend_valid_d = pend_valid_q;
    pwm_d        = bus.EN & ({1'b0, bus.CNT} < duty_eff);
    wrap_d       = wrap;

    if (bus.EN) begin
      // Apply the old pending value first so a same-cycle LOAD queues for the next wrap.
      if (wrap && pend_valid_q) begin
        duty_act_d   = duty_pend_q;
        pend_valid_d = 1'b0;
      end
      if (bus.LOAD) begin
        duty_pend_d  = duty_clamped;
        pend_valid_d = 1'b1;
      end
    end else if (bus.LOAD) begin
      duty_act_d   = duty_clamped;
      pend_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q        <= '0;
      duty_act_q   <= '0;
      duty_pend_q  <= '0;
      pend_valid_q <= 1'b0;
      pwm_q        <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      duty_act_q   <= duty_act_d;
      duty_pend_q  <= duty_pend_d;
      pend_valid_q <= pend_valid_d;
      pwm_q        <= pwm_d;
      wrap_q       <= wrap_d;
    end
  end

  assign bus.PWM  = pwm_q;
  assign bus.WRAP = wrap_q;
  assign bus.BUSY = pend_valid_q;

endmodule

// File: tb/tb_pwm_compare.sv
// Scoreboard bench for pwm_compare: directed scenarios followed by random traffic, all
// checked against a period-level duty model.
module tb_pwm_compare;

  typedef struct packed {
    logic pwm;
    logic wrap;
    logic busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pwm_compare_if #(.WIDTH(4)) bus ();

  pwm_compare #(.WIDTH(4)) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  // Reference model state: active duty, at most one pending duty, last counter value seen.
  int act_duty = 0;
  int pend_q[$];
  int prev_cnt = 0;
  int cnt = 15;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: one registered output set per clock edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        chk("pwm", {7'd0, bus.PWM}, {7'd0, mon_e.pwm});
        chk("wrap", {7'd0, bus.WRAP}, {7'd0, mon_e.wrap});
        chk("busy", {7'd0, bus.BUSY}, {7'd0, mon_e.busy});
      end
    end
  end

  task automatic model_step(input bit e, input bit l, input int d);
    exp_t x;
    bit   is_wrap;
    int   eff;
    int   dc;
    dc      = (d > 16) ? 16 : d;
    is_wrap = e && (prev_cnt == 15) && (cnt == 0);
    eff     = (is_wrap && pend_q.size() != 0) ? pend_q[0] : act_duty;
    x.pwm   = e && (cnt < eff);
    x.wrap  = is_wrap;
    if (e) begin
      if (is_wrap && pend_q.size() != 0) act_duty = pend_q.pop_front();
      if (l) begin
        pend_q.delete();
        pend_q.push_back(dc);
      end
    end else if (l) begin
      act_duty = dc;
      pend_q.delete();
    end
    prev_cnt = cnt;
    x.busy   = (pend_q.size() != 0);
    sb_q.push_back(x);
  endtask

  task automatic drive(input bit e, input bit l, input int d, input bit crst);
    cnt         = crst ? 0 : (cnt + 1) % 16;
    bus.EN      = e;
    bus.CNT     = 4'(cnt);
    bus.LOAD    = l;
    bus.DUTY_IN = 5'(d);
    model_step(e, l, d);
  endtask

  task automatic cycle(input bit e, input bit l, input int d, input bit crst);
    @(posedge clk);
    #2;
    drive(e, l, d, crst);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 0, 1'b0);
  endtask

  task automatic run_until(input int v);
    for (int i = 0; i < 32 && cnt != v; i++) cycle(1'b1, 1'b0, 0, 1'b0);
  endtask

  task automatic do_reset(input int hold);
    exp_t z;
    z = '0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_pwm", {7'd0, bus.PWM}, 8'd0);
    chk("rst_wrap", {7'd0, bus.WRAP}, 8'd0);
    chk("rst_busy", {7'd0, bus.BUSY}, 8'd0);
    act_duty = 0;
    pend_q.delete();
    prev_cnt = 0;
    sb_q.push_back(z);
    for (int i = 1; i < hold; i++) begin
      @(posedge clk);
      #2;
      cnt     = (cnt + 1) % 16;
      bus.CNT = 4'(cnt);
      sb_q.push_back(z);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 0, 1'b0);
  endtask

  initial begin
    bus.EN      = 1'b0;
    bus.CNT     = '0;
    bus.LOAD    = 1'b0;
    bus.DUTY_IN = '0;
    #3;
    chk("init_pwm", {7'd0, bus.PWM}, 8'd0);
    chk("init_wrap", {7'd0, bus.WRAP}, 8'd0);
    chk("init_busy", {7'd0, bus.BUSY}, 8'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 0, 1'b0);

    // Idle counting: wraps only
    run(40);

    // Basic duty loaded while disabled
    cycle(1'b0, 1'b1, 5, 1'b0);
    run(40);

    // Deferred update mid-period
    run_until(6);
    cycle(1'b1, 1'b1, 12, 1'b0);
    run(30);

    // LOAD coinciding with the wrap
    run_until(10);
    cycle(1'b1, 1'b1, 3, 1'b0);
    run_until(15);
    cycle(1'b1, 1'b1, 9, 1'b0);
    run(36);

    // Extremes and clamp
    cycle(1'b1, 1'b1, 0, 1'b0);
    run(36);
    cycle(1'b1, 1'b1, 16, 1'b0);
    run(36);
    cycle(1'b1, 1'b1, 31, 1'b0);
    run(36);

    // False wrap: upstream counter reset at 9, held at zero
    cycle(1'b1, 1'b1, 7, 1'b0);
    run_until(9);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 0, 1'b1);
    run(40);

    // Pending survives a disabled stretch
    cycle(1'b1, 1'b1, 11, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 0, 1'b0);
    run(36);

    // Reset mid-period drops pending state
    cycle(1'b1, 1'b1, 14, 1'b0);
    do_reset(3);
    run(20);

    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0),
            int'($urandom_range(0, 31)), ($urandom_range(0, 29) == 0));
      if ($urandom_range(0, 999) == 0) do_reset(2);
    end

    @(posedge clk);
    @(posedge clk);
    #3;
    chk("drain", 8'(sb_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
